// File: rtl/pix28_axi_pkg.sv
// Shared types and constants for the pix28 AXI4-Lite register initiator.
// Holds the master FSM state encoding, AXI response codes and default widths.
package pix28_axi_pkg;

  localparam int AXI_DATA_W  = 32;
  localparam int AXI_ADDR_W  = 11;
  localparam int TIMEOUT_DEF = 1024;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } axi_mst_state_t;

endpackage

// File: rtl/axi4lite_master_for_pix28_fw.sv
// Single-outstanding AXI4-Lite initiator toward the pix28 register slave.
// Turns one register command into one AXI transaction, with timeout abort.
module axi4lite_master_for_pix28_fw
  import pix28_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter int C_TIMEOUT_CYCLES   = TIMEOUT_DEF
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam bit TO_EN = C_TIMEOUT_CYCLES > 0;
  localparam int TW = TO_EN ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(C_TIMEOUT_CYCLES);

  axi_mst_state_t state, state_n;

  logic          aw_done, aw_done_n;
  logic          w_done, w_done_n;
  logic [TW-1:0] timer, timer_n, tick;
  logic          expire, fire_to;

  logic          cmd_ready_n;
  logic          rsp_valid_n, rsp_timeout_n;
  logic [DW-1:0] rsp_rdata_n;
  logic [1:0]    rsp_resp_n;
  logic [AW-1:0] awaddr_n, araddr_n;
  logic [DW-1:0] wdata_n;
  logic [SW-1:0] wstrb_n;
  logic          awvalid_n, wvalid_n, bready_n;
  logic          arvalid_n, rready_n;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // tick is the cycle count including the current one
  assign tick   = timer + 1'b1;
  assign expire = TO_EN && (tick == TLIM);

  always_comb begin
    state_n       = state;
    aw_done_n     = aw_done;
    w_done_n      = w_done;
    timer_n       = tick;
    fire_to       = 1'b0;
    cmd_ready_n   = 1'b0;
    rsp_valid_n   = rsp_valid;
    rsp_timeout_n = rsp_timeout;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;
    awaddr_n      = M_AXI_AWADDR;
    araddr_n      = M_AXI_ARADDR;
    wdata_n       = M_AXI_WDATA;
    wstrb_n       = M_AXI_WSTRB;
    awvalid_n     = M_AXI_AWVALID;
    wvalid_n      = M_AXI_WVALID;
    bready_n      = M_AXI_BREADY;
    arvalid_n     = M_AXI_ARVALID;
    rready_n      = M_AXI_RREADY;

    unique case (state)
      IDLE: begin
        timer_n     = '0;
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          if (cmd_write) begin
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            wstrb_n   = cmd_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WR_REQ;
          end else begin
            araddr_n  = cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        aw_done_n = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_done_n  = w_done | (M_AXI_WVALID & M_AXI_WREADY);
        awvalid_n = ~aw_done_n;
        wvalid_n  = ~w_done_n;
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end else if (expire) begin
          fire_to = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          bready_n      = 1'b0;
          rsp_resp_n    = M_AXI_BRESP;
          rsp_rdata_n   = '0;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = RSP;
        end else if (expire) begin
          fire_to = 1'b1;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_RESP;
        end else if (expire) begin
          fire_to = 1'b1;
        end
      end
      RD_RESP: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rready_n      = 1'b0;
          rsp_resp_n    = M_AXI_RRESP;
          rsp_rdata_n   = M_AXI_RDATA;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = RSP;
        end else if (expire) begin
          fire_to = 1'b1;
        end
      end
      RSP: begin
        timer_n = '0;
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // a completed handshake has already claimed the cycle above
    if (fire_to) begin
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_resp_n    = AXI_RESP_SLVERR;
      rsp_rdata_n   = '0;
      rsp_timeout_n = 1'b1;
      rsp_valid_n   = 1'b1;
      state_n       = RSP;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      timer         <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      state         <= state_n;
      aw_done       <= aw_done_n;
      w_done        <= w_done_n;
      timer         <= timer_n;
      cmd_ready     <= cmd_ready_n;
      rsp_valid     <= rsp_valid_n;
      rsp_timeout   <= rsp_timeout_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_resp      <= rsp_resp_n;
      M_AXI_AWADDR  <= awaddr_n;
      M_AXI_ARADDR  <= araddr_n;
      M_AXI_WDATA   <= wdata_n;
      M_AXI_WSTRB   <= wstrb_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_BREADY  <= bready_n;
      M_AXI_ARVALID <= arvalid_n;
      M_AXI_RREADY  <= rready_n;
    end
  end

endmodule

// File: tb/tb_axi4lite_master_for_pix28_fw.sv
// Bench for the pix28 AXI4-Lite initiator: reactive slave model plus
// a response scoreboard fed by the stimulus thread.
module tb_axi4lite_master_for_pix28_fw;

  logic        clk;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [10:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [10:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  axi4lite_master_for_pix28_fw #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(11),
    .C_TIMEOUT_CYCLES(8)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(areset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_rsp = 0;
  int exp_n = 0;
  int rise_cyc = 0;
  int hs_cyc = 0;
  int acc_cyc = 0;
  int aw_cycles = 0, w_cycles = 0, ar_cycles = 0, aw_unstable = 0;

  // slave model knobs and state
  int          aw_delay = 0;
  bit          ar_hang = 0;
  bit          b_hold = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] sw_write32_0 = 32'h0;
  logic [10:0] s_awaddr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  int          n_bhs = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r,
                      input logic t);
    exp_t e;
    e.rdata = d;
    e.resp  = r;
    e.to    = t;
    exp_q.push_back(e);
    exp_n++;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // slave: sample handshakes at negedge, drive new values just after posedge
  initial begin
    int  aw_cnt;
    bit  aw_got, w_got, ar_got, b_clr, r_clr;
    aw_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (areset) begin
        aw_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        awready = 0; wready = 0; bvalid = 0;
        arready = 0; rvalid = 0;
        continue;
      end
      b_clr = 0;
      r_clr = 0;
      if (awvalid && awready) begin
        aw_got = 1; s_awaddr = awaddr; aw_cnt = 0;
      end
      if (wvalid && wready) begin
        w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
      end
      if (bvalid && bready) begin
        b_clr = 1; n_bhs++;
      end
      if (arvalid && arready) ar_got = 1;
      if (rvalid && rready) r_clr = 1;
      @(posedge clk);
      #1;
      if (awvalid && !aw_got) begin
        awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        awready = 0;
        aw_cnt = 0;
      end
      wready = wvalid && !w_got;
      if (b_clr) bvalid = 0;
      if (aw_got && w_got && !b_hold && !bvalid) begin
        bvalid = 1;
        bresp = bresp_cfg;
        if (s_awaddr == 11'h000)
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) sw_write32_0[8*b +: 8] = s_wdata[8*b +: 8];
        aw_got = 0;
        w_got = 0;
      end
      arready = arvalid && !ar_hang && !ar_got;
      if (r_clr) rvalid = 0;
      if (ar_got && !rvalid) begin
        rvalid = 1;
        rdata = rd_val;
        rresp = 2'b00;
        ar_got = 0;
      end
    end
  end

  // monitor and scoreboard
  initial begin
    bit          prev_rv, prev_awv;
    logic [10:0] prev_awaddr;
    exp_t        e;
    prev_rv = 0;
    prev_awv = 0;
    prev_awaddr = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_rv = 0;
        prev_awv = 0;
        continue;
      end
      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      if (arvalid) ar_cycles++;
      if (awvalid && prev_awv && awaddr != prev_awaddr) aw_unstable++;
      prev_awv = awvalid;
      prev_awaddr = awaddr;
      if (rsp_valid && !prev_rv) rise_cyc = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc;
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
      end
    end
  end

  task automatic do_cmd(input logic w, input logic [10:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    bit ok;
    cmd_valid = 1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    check("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 40; i++) begin
      if (n_rsp >= target) break;
      @(negedge clk);
    end
    check("rsp_arrived", 32'(n_rsp), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_ctrl", 32'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp,
                           awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr", 32'({awaddr, araddr}), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb0, nr, stable_bad;
    bit seen;
    logic [31:0] snap_d;
    logic [1:0]  snap_r;
    logic        snap_t;

    areset = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
    repeat (3) @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;
    areset = 0;
    @(negedge clk);
    check("cmd_ready_at_release", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // zero-wait write
    push(32'h0, 2'b00, 1'b0);
    do_cmd(1'b1, 11'h000, 32'hA5A5_0001, 4'hF);
    wait_rsp(exp_n);
    check("wr_latency", 32'(rise_cyc - acc_cyc), 32'd3);
    check("sw_write32_0", sw_write32_0, 32'hA5A5_0001);
    check("wr_b_hs", 32'(n_bhs), 32'd1);

    // zero-wait read
    rd_val = 32'h1234_5678;
    push(32'h1234_5678, 2'b00, 1'b0);
    do_cmd(1'b0, 11'h100, 32'h0, 4'h0);
    wait_rsp(exp_n);
    check("rd_latency", 32'(rise_cyc - acc_cyc), 32'd3);

    // AWREADY late by 3 cycles, WREADY immediate
    aw_delay = 3;
    bresp_cfg = 2'b01;
    aw_cycles = 0; w_cycles = 0; aw_unstable = 0;
    nb0 = n_bhs;
    push(32'h0, 2'b01, 1'b0);
    do_cmd(1'b1, 11'h004, 32'hDEAD_BEEF, 4'h3);
    wait_rsp(exp_n);
    check("skew_aw_cycles", 32'(aw_cycles), 32'd4);
    check("skew_w_cycles", 32'(w_cycles), 32'd1);
    check("skew_aw_stable", 32'(aw_unstable), 32'd0);
    check("skew_b_hs", 32'(n_bhs - nb0), 32'd1);
    check("skew_awaddr", 32'(s_awaddr), 32'h004);
    check("skew_wdata", s_wdata, 32'hDEAD_BEEF);
    check("skew_wstrb", 32'(s_wstrb), 32'h3);
    aw_delay = 0;
    bresp_cfg = 2'b00;

    // hung slave: no ARREADY ever
    ar_hang = 1;
    ar_cycles = 0;
    push(32'h0, 2'b10, 1'b1);
    do_cmd(1'b0, 11'h100, 32'h0, 4'h0);
    wait_rsp(exp_n);
    check("hung_ar_cycles", 32'(ar_cycles), 32'd8);
    check("hung_latency", 32'(rise_cyc - acc_cyc), 32'd9);
    ar_hang = 0;

    // response backpressure for 5 cycles
    rsp_ready = 0;
    rd_val = 32'h0BAD_F00D;
    push(32'h0BAD_F00D, 2'b00, 1'b0);
    do_cmd(1'b0, 11'h104, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("bp_rsp_seen", 32'(seen), 32'd1);
    snap_d = rsp_rdata;
    snap_r = rsp_resp;
    snap_t = rsp_timeout;
    stable_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_rdata != snap_d ||
          rsp_resp != snap_r || rsp_timeout != snap_t)
        stable_bad++;
    end
    check("bp_stable", 32'(stable_bad), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1;
    push(32'h0, 2'b00, 1'b0);
    do_cmd(1'b1, 11'h000, 32'h0000_0077, 4'h1);
    check("bp_next_accept", 32'(acc_cyc - hs_cyc), 32'd1);
    wait_rsp(exp_n);
    check("bp_sw_write32_0", sw_write32_0, 32'hA5A5_0077);

    // reset while waiting on B
    b_hold = 1;
    nr = n_rsp;
    do_cmd(1'b1, 11'h000, 32'h1111_2222, 4'hF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bready) begin
        seen = 1;
        break;
      end
    end
    check("rst_bready_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    areset = 1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;
    areset = 0;
    b_hold = 0;
    repeat (6) @(negedge clk);
    check("rst_no_rsp", 32'(n_rsp), 32'(nr));
    check("rst_no_commit", sw_write32_0, 32'hA5A5_0077);
    @(posedge clk); #1;
    rd_val = 32'hCAFE_0001;
    push(32'hCAFE_0001, 2'b00, 1'b0);
    do_cmd(1'b0, 11'h100, 32'h0, 4'h0);
    wait_rsp(exp_n);
    check("post_rst_latency", 32'(rise_cyc - acc_cyc), 32'd3);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
